// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared SPI definitions: FSM state encoding, fixed bus mode
//             (CPOL/CPHA) and default master parameters. The peer slave
//             imports the same mode constants.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Master sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } spi_state_e;

  // Bus mode: sclk idles low, data launched on rising edge, sampled on falling
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b1;

  // Default master configuration
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CLK_DIV    = 2;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_if
//  Brief    : Host handshake plus serial pins of the SPI master, with
//             master (the DUT side) and slave (the user side) modports.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  start;
  logic [DATA_WIDTH-1:0] txData;
  logic [DATA_WIDTH-1:0] rxData;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  csN;

  modport master (
    input  start, txData, miso,
    output rxData, busy, done, sclk, mosi, csN
  );

  modport slave (
    output start, txData, miso,
    input  rxData, busy, done, sclk, mosi, csN
  );
endinterface
`default_nettype wire

// File: rtl/spi_half_period_tick.sv
`default_nettype none
// ============================================================================
//  Module   : spi_half_period_tick
//  Brief    : Divider counter running 0..CLK_DIV-1; emits a one-cycle tick
//             on the last count of each sclk half-period. i_clear holds it
//             at zero so every state starts with a full half-period.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_half_period_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int               CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count up, wrapping on terminal count or when cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Brief    : Mode-1 (CPOL=0, CPHA=1) MSB-first SPI master. Shifts one word
//             out on mosi while shifting one word in from miso. All outputs
//             are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic         writeClk,
  input  logic         reset,
  spi_master_if.master bus
);

  localparam int BCNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BCNT_W-1:0] C_LAST_BIT = BCNT_W'(DATA_WIDTH);

  // Each sclk level must last at least two system clocks for the peer slave;
  // the sequencing below also only implements the fixed mode.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be 2 or more");
  end
  if (CPOL != 1'b0 || CPHA != 1'b1) begin : g_bad_mode
    $error("spi_master: only CPOL=0, CPHA=1 is implemented");
  end

  spi_state_e            r_state,  w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift,  w_shift_nxt;
  logic [BCNT_W-1:0]     r_bitcnt, w_bitcnt_nxt;
  logic [DATA_WIDTH-1:0] r_rxData, w_rxData_nxt;
  logic                  r_csN,    w_csN_nxt;
  logic                  r_sclk,   w_sclk_nxt;
  logic                  r_mosi,   w_mosi_nxt;
  logic                  r_busy,   w_busy_nxt;
  logic                  r_done,   w_done_nxt;
  logic                  w_tick;
  logic                  w_div_clear;

  // Divider stays cleared while idle so SETUP starts from count zero
  assign w_div_clear = (r_state == ST_IDLE);

  spi_half_period_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (writeClk),
    .rst     (reset),
    .i_clear (w_div_clear),
    .o_tick  (w_tick)
  );

  // State and output registers
  always_ff @(posedge writeClk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_rxData <= '0;
      r_csN    <= 1'b1;
      r_sclk   <= CPOL;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_rxData <= w_rxData_nxt;
      r_csN    <= w_csN_nxt;
      r_sclk   <= w_sclk_nxt;
      r_mosi   <= w_mosi_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a tick fires
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_rxData_nxt = r_rxData;
    w_csN_nxt    = r_csN;
    w_sclk_nxt   = r_sclk;
    w_mosi_nxt   = r_mosi;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_shift_nxt  = bus.txData;
          w_bitcnt_nxt = '0;
          w_csN_nxt    = 1'b0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_sclk_nxt  = 1'b1;
          w_mosi_nxt  = r_shift[DATA_WIDTH-1];
          w_state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // Falling sclk: capture miso into the LSB as the word moves up
        if (w_tick) begin
          w_sclk_nxt   = 1'b0;
          w_shift_nxt  = {r_shift[DATA_WIDTH-2:0], bus.miso};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          w_state_nxt  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_tick) begin
          if (r_bitcnt == C_LAST_BIT) begin
            w_csN_nxt    = 1'b1;
            w_mosi_nxt   = 1'b0;
            w_busy_nxt   = 1'b0;
            w_rxData_nxt = r_shift;
            w_done_nxt   = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_sclk_nxt  = 1'b1;
            w_mosi_nxt  = r_shift[DATA_WIDTH-1];
            w_state_nxt = ST_HIGH;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.rxData = r_rxData;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.sclk   = r_sclk;
  assign bus.mosi   = r_mosi;
  assign bus.csN    = r_csN;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Brief    : Scoreboard bench for spi_master. Two instances: CLK_DIV=2 with
//             loopback / constant miso, and CLK_DIV=3 against a mode-1 slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;
  import spi_pkg::*;

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] rx;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_if #(.DATA_WIDTH(8)) bus0 ();
  spi_master_if #(.DATA_WIDTH(8)) bus1 ();

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut0 (
    .writeClk (clk),
    .reset    (rst),
    .bus      (bus0)
  );

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(3)) dut1 (
    .writeClk (clk),
    .reset    (rst),
    .bus      (bus1)
  );

  // miso source for dut0: 0 = loopback, 1 = constant high, 2 = constant low
  int mode0 = 0;
  always_comb bus0.miso = (mode0 == 0) ? bus0.mosi : (mode0 == 1);

  // Mode-1 slave for dut1: launch on sclk rise, capture on sclk fall
  logic [7:0] slv_pre = 8'h00;
  logic [7:0] s_tx    = 8'h00;
  logic [7:0] s_rx    = 8'h00;
  logic       s_miso  = 1'b0;
  assign bus1.miso = s_miso;

  always @(negedge bus1.csN) begin
    s_tx <= slv_pre;
    s_rx <= 8'h00;
  end
  always @(posedge bus1.sclk) begin
    if (!bus1.csN) begin
      s_miso <= s_tx[7];
      s_tx   <= {s_tx[6:0], 1'b0};
    end
  end
  always @(negedge bus1.sclk) begin
    if (!bus1.csN) s_rx <= {s_rx[6:0], bus1.mosi};
  end

  exp_t q0[$];
  exp_t q1[$];

  // Monitor state per instance
  logic       prev_cs[2] = '{1'b1, 1'b1};
  logic       prev_sc[2] = '{1'b0, 1'b0};
  int         run[2]     = '{0, 0};
  int         rises[2]   = '{0, 0};
  logic [7:0] cap[2]     = '{8'h00, 8'h00};

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  // Reference model: what the master must receive for a given miso source
  function automatic logic [7:0] ref_rx(input logic [7:0] tx, input int mode, input logic [7:0] pre);
    case (mode)
      0:       return tx;
      1:       return 8'hFF;
      2:       return 8'h00;
      default: return pre;
    endcase
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic cs, input logic sc, input logic mo,
                     input logic dn, input logic bz, input logic [7:0] rx, input logic [7:0] srx);
    exp_t e;
    // Every sclk level inside a frame (setup low included) lasts CLK_DIV cycles
    if (prev_cs[d] == 1'b0) begin
      if (cs || (sc != prev_sc[d])) begin
        chk($sformatf("sclk_width%0d", d), run[d], div_of(d));
        run[d] = 1;
      end else begin
        run[d]++;
      end
    end else begin
      run[d] = 1;
    end
    if (!cs && sc && !prev_sc[d]) begin
      rises[d]++;
      cap[d] = {cap[d][6:0], mo};
    end
    if (dn) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done%0d: actual done=1 required no done at t=%0t", d, $time);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rxData%0d", d), rx, e.rx);
        chk($sformatf("mosi_word%0d", d), cap[d], e.tx);
        chk($sformatf("sclk_rises%0d", d), rises[d], 8);
        chk($sformatf("done_cycle%0d", d), cyc, e.cyc);
        chk($sformatf("csN_at_done%0d", d), cs, 1);
        chk($sformatf("busy_at_done%0d", d), bz, 0);
        chk($sformatf("mosi_at_done%0d", d), mo, 0);
        if (d == 1) chk("slave_rx", srx, e.tx);
      end
      rises[d] = 0;
    end
    prev_cs[d] = cs;
    prev_sc[d] = sc;
  endtask

  // Monitor: sample DUT outputs on the inactive clock edge
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        prev_cs[d] = 1'b1;
        prev_sc[d] = 1'b0;
        run[d]     = 0;
        rises[d]   = 0;
        cap[d]     = 8'h00;
      end
    end else begin
      mon(0, bus0.csN, bus0.sclk, bus0.mosi, bus0.done, bus0.busy, bus0.rxData, 8'h00);
      mon(1, bus1.csN, bus1.sclk, bus1.mosi, bus1.done, bus1.busy, bus1.rxData, s_rx);
    end
  end

  task automatic check_reset_vals();
    chk("rst_csN0",  bus0.csN,    1);
    chk("rst_sclk0", bus0.sclk,   0);
    chk("rst_mosi0", bus0.mosi,   0);
    chk("rst_busy0", bus0.busy,   0);
    chk("rst_done0", bus0.done,   0);
    chk("rst_rx0",   bus0.rxData, 0);
    chk("rst_csN1",  bus1.csN,    1);
    chk("rst_sclk1", bus1.sclk,   0);
    chk("rst_mosi1", bus1.mosi,   0);
    chk("rst_busy1", bus1.busy,   0);
    chk("rst_done1", bus1.done,   0);
    chk("rst_rx1",   bus1.rxData, 0);
  endtask

  // Called just after a rising edge; start is accepted on the next edge
  task automatic issue(input int d, input logic [7:0] tx, input int mode, input logic [7:0] pre);
    exp_t e;
    e.tx  = tx;
    e.rx  = ref_rx(tx, mode, pre);
    e.cyc = cyc + 1 + 17 * div_of(d);
    if (d == 0) begin
      mode0       = mode;
      bus0.txData = tx;
      bus0.start  = 1'b1;
      q0.push_back(e);
    end else begin
      slv_pre     = pre;
      bus1.txData = tx;
      bus1.start  = 1'b1;
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (d == 0) begin
      bus0.start  = 1'b0;
      bus0.txData = 8'($urandom);
    end else begin
      bus1.start  = 1'b0;
      bus1.txData = 8'($urandom);
    end
  endtask

  // Returns one time unit after the edge that raised done
  task automatic wait_done(input int d);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = (d == 0) ? bus0.done : bus1.done;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout%0d: actual no done required done within 300 cycles", d);
    end
  endtask

  task automatic run_xfer(input int d, input logic [7:0] tx, input int mode, input logic [7:0] pre);
    issue(d, tx, mode, pre);
    wait_done(d);
  endtask

  // Asynchronous reset pulse spanning one falling clock edge
  task automatic async_reset(input int off);
    #(off);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check_reset_vals();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic ok;
    bus0.start  = 1'b0;
    bus1.start  = 1'b0;
    bus0.txData = 8'h00;
    bus1.txData = 8'h00;

    // Reset before any clock edge
    #2 rst = 1'b1;
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Loopback, then constant miso; each start lands in the done cycle
    run_xfer(0, 8'hA5, 0, 8'h00);
    run_xfer(0, 8'h00, 1, 8'h00);
    run_xfer(0, 8'h00, 2, 8'h00);

    // Second start while busy must be ignored
    issue(0, 8'h3C, 0, 8'h00);
    repeat (9) @(posedge clk);
    #1;
    bus0.txData = 8'hC3;
    bus0.start  = 1'b1;
    @(posedge clk);
    #1;
    bus0.start  = 1'b0;
    wait_done(0);

    // Reset after the third sclk rise: no done, then a clean transfer
    issue(0, 8'($urandom), 0, 8'h00);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = (rises[0] >= 3);
    end
    chk("third_rise_seen", ok, 1);
    async_reset(2);
    repeat (40) @(posedge clk);
    #1;
    run_xfer(0, 8'h81, 0, 8'h00);

    // Slave exchange at CLK_DIV = 3
    run_xfer(1, 8'h96, 3, 8'h5A);

    // Randomized transfers on both instances
    for (int i = 0; i < 16; i++) begin
      int         d;
      logic [7:0] tx;
      d  = $urandom_range(0, 1);
      tx = 8'($urandom);
      if (d == 0) run_xfer(0, tx, $urandom_range(0, 2), 8'h00);
      else        run_xfer(1, tx, 3, 8'($urandom));
    end

    // Random-time reset inside a CLK_DIV = 3 transfer, then recover
    issue(1, 8'($urandom), 3, 8'($urandom));
    repeat ($urandom_range(2, 40)) @(posedge clk);
    #1;
    async_reset($urandom_range(1, 2));
    repeat (60) @(posedge clk);
    #1;
    run_xfer(1, 8'($urandom), 3, 8'($urandom));
    run_xfer(0, 8'($urandom), 0, 8'h00);

    repeat (10) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

SPI master for the mining board's host link. It generates `sclk`, chip select and MOSI from the system clock, and shifts one 8-bit word out while shifting one word in. The SPI mode is fixed at CPOL = 0, CPHA = 1, MSB first: MOSI changes on the rising edge of `sclk`, and MISO is sampled on the falling edge. The block is the initiating end of the link whose peripheral side is the oversampling shift-register slave. That slave needs each `sclk` level held for at least two system clocks.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer.
- `CLK_DIV`, default 2: system clocks per `sclk` half-period. Legal values are 2 or more; the elaboration check fails below 2.
- `writeClk`  in  1: the system clock. This is the single clock; all logic runs on its rising edge.
- `reset`  in  1: reset, asynchronous and active-high.
- `start`  in  1: one-cycle request. It is sampled only while `busy` = 0.
- `txData`  in  DATA_WIDTH: word to send. It is latched on an accepted `start`.
- `rxData`  out  DATA_WIDTH: last received word. It updates in the same cycle that `done` is high and holds until the next `done`.
- `busy`  out  1: high from the cycle after `start` is accepted until the cycle `done` is asserted.
- `done`  out  1: single-cycle pulse marking the end of a transfer.
- `sclk`  out  1: serial clock. It idles low.
- `mosi`  out  1: serial data out. It idles low.
- `miso`  in  1: serial data in. It is treated as asynchronous and sampled directly; no synchronizer is required at `CLK_DIV` ≥ 2.
- `csN`  out  1: chip select, active low.

## Operation
- All outputs, including `csN`, `sclk` and `mosi`, are registered.
- Reset values: `csN` = 1, `sclk` = 0, `mosi` = 0, `busy` = 0, `done` = 0, `rxData` = 0. Internally the state is IDLE and all counters are 0.
- State machine: IDLE → SETUP → HIGH ↔ LOW → IDLE.
  - IDLE: when `start` = 1, load the shift register with `txData`, set `csN` to 0, set `busy` to 1, clear the divider and bit counter, and go to SETUP.
  - SETUP: hold `csN` low and `sclk` low for `CLK_DIV` cycles. At terminal count, set `sclk` to 1, drive `mosi` from the shift register MSB, and go to HIGH.
  - HIGH: last `CLK_DIV` cycles. At terminal count, set `sclk` to 0 and shift the register as {shift[DATA_WIDTH-2:0], `miso`}. Increment the bit counter and go to LOW.
  - LOW: last `CLK_DIV` cycles. At terminal count, branch on the bit counter:
    - If the counter equals `DATA_WIDTH`: set `csN` to 1, set `mosi` to 0, set `busy` to 0, load `rxData` from the shift register, pulse `done`, and go to IDLE.
    - Otherwise: set `sclk` to 1, drive `mosi` from the shift register MSB, and go to HIGH.
- The received word fills from the LSB, so after `DATA_WIDTH` samples the register holds the received word in MSB-first order.
- Divider: one counter runs 0..`CLK_DIV`-1 and is shared by every state. The bit counter is $clog2(DATA_WIDTH+1) bits wide.
- Boundary conditions:
  - A `start` while `busy` = 1 is ignored, and `txData` is not re-latched.
  - A `start` in the same cycle as `done` = 1 is accepted, because the state is already IDLE. `csN` is then high for exactly one cycle between transfers.
  - A `reset` assertion mid-transfer immediately forces all outputs to their reset values. The partial word is discarded, `rxData` is cleared, and no `done` is produced.
  - `txData` changes after acceptance have no effect on the transfer in progress.

## Timing
- Accepted `start` at edge 0: `csN` falls and `busy` rises after edge 0.
- The first `sclk` rise follows edge `CLK_DIV`. The k-th rise (k = 1..DATA_WIDTH) follows edge (2k-1)·`CLK_DIV`.
- The k-th fall, which is when MISO is sampled, follows edge 2k·`CLK_DIV`.
- `done`, `csN` rising, `busy` falling and the `rxData` update all follow edge (2·DATA_WIDTH+1)·`CLK_DIV`. For the defaults this is edge 34.
- Throughput with back-to-back starts is one word per (2·DATA_WIDTH+1)·`CLK_DIV`+1 cycles.
- `mosi` is stable for a full `sclk` period around each falling edge.

## Structure
- Shared package `spi_pkg` holds:
  - the state encoding (IDLE, SETUP, HIGH, LOW);
  - the mode constants CPOL = 0 and CPHA = 1;
  - the default `CLK_DIV` and `DATA_WIDTH`.
  The peer slave imports the same mode constants.
- One sub-module: `spi_half_period_tick`. It is the divider counter; it has a clear input and emits a one-cycle terminal-count tick. Everything else is the FSM plus the shift and bit counters in `spi_master`.

## Test plan
- Reset, with `reset` = 1 at arbitrary times → `csN` = 1, `sclk` = 0, `mosi` = 0, `busy` = 0, `done` = 0, `rxData` = 0, all asynchronously, without waiting for a clock edge.
- Loopback test with `miso` = `mosi`, `txData` = 0xA5 and `CLK_DIV` = 2:
  - `mosi` at the 8 rising edges reads 1,0,1,0,0,1,0,1;
  - there are exactly 8 `sclk` rises;
  - `done` occurs 34 cycles after `start`;
  - `rxData` = 0xA5.
- Constant MISO with `txData` = 0x00: `miso` held at 1 → `rxData` = 0xFF; `miso` held at 0 → `rxData` = 0x00.
- Start while busy: `start` with 0x3C, then `start` with 0xC3 at cycle 10 → only 0x3C appears on `mosi`, and exactly one `done` pulse occurs.
- Reset mid-transfer: `reset` pulsed after the 3rd `sclk` rise → no `done`. Then `start` with 0x81 → a clean 8-bit transfer, and a loopback `rxData` = 0x81.
- Slave model and `CLK_DIV` = 3: a CPHA = 1 slave model preloaded with 0x5A, with `txData` = 0x96 → the master gets `rxData` = 0x5A and the slave receives 0x96. `sclk` high and low widths are each exactly 3 cycles.
